// File: rtl/mysystem_spi_pkg.sv
// Shared definitions for the mysystem SPI master: register map, STATUS/CONTROL
// bit positions and FSM state encoding.
package mysystem_spi_pkg;

    localparam logic [1:0] ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] ADDR_RXDATA  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;

    localparam int CTRL_KEEP_CS  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SCLK_HI = 3'd2,
        ST_SCLK_LO = 3'd3,
        ST_HOLD    = 3'd4
    } spi_state_t;

endpackage

// File: rtl/mysystem_spi_clkdiv.sv
// Phase timer: loadable down-counter that holds at zero; o_zero marks the last
// cycle of the current SPI phase.
module mysystem_spi_clkdiv #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mysystem_spi_master_ctrl.sv
// Avalon-MM SPI master (mode 0, MSB first): one transfer per TXDATA write,
// received word latched into RXDATA when chip-select phase ends.
//
// state      | meaning
// ST_IDLE    | waiting for TXDATA write; csn high unless keep_cs
// ST_SETUP   | csn low, first MOSI bit presented, sclk low
// ST_SCLK_HI | sclk high, MISO captured on entry
// ST_SCLK_LO | sclk low, next MOSI bit presented on entry
// ST_HOLD    | sclk low after last bit, then RXDATA/rx_valid updated
module mysystem_spi_master_ctrl
    import mysystem_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        spi_csn,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    spi_state_t            r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift, r_rxdata;
    logic [BW-1:0]         r_bitcnt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_keep_cs, r_rx_valid, r_overrun;
    logic                  r_csn, r_sclk, r_mosi;

    logic w_wr, w_wr_tx, w_wr_stat, w_wr_ctrl, w_rd_rx, w_keep_nxt, w_busy;
    logic w_zero, w_load_cnt, w_start, w_enter_hi, w_enter_lo, w_enter_hold, w_done;
    logic w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_tx   = w_wr & (address == ADDR_TXDATA);
    assign w_wr_stat = w_wr & (address == ADDR_STATUS);
    assign w_wr_ctrl = w_wr & (address == ADDR_CONTROL);
    assign w_rd_rx   = chipselect & ~read_n & (address == ADDR_RXDATA);
    assign w_busy    = (r_state != ST_IDLE);
    assign w_unused  = ^writedata;

    // A CONTROL write landing on the same edge already governs csn release.
    assign w_keep_nxt = w_wr_ctrl ? writedata[CTRL_KEEP_CS] : r_keep_cs;

    mysystem_spi_clkdiv #(.W(DIV_WIDTH)) u_clkdiv (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load_cnt),
        .i_load_val (r_div),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_enter_hi   = 1'b0;
        w_enter_lo   = 1'b0;
        w_enter_hold = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_tx) begin
                    w_state_nxt = ST_SETUP;
                    w_start     = 1'b1;
                end
            end
            ST_SETUP, ST_SCLK_LO: begin
                if (w_zero) begin
                    w_state_nxt = ST_SCLK_HI;
                    w_enter_hi  = 1'b1;
                end
            end
            ST_SCLK_HI: begin
                if (w_zero) begin
                    if (r_bitcnt == '0) begin
                        w_state_nxt  = ST_HOLD;
                        w_enter_hold = 1'b1;
                    end else begin
                        w_state_nxt = ST_SCLK_LO;
                        w_enter_lo  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_load_cnt = w_start | w_enter_hi | w_enter_lo | w_enter_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_rxdata   <= '0;
            r_bitcnt   <= '0;
            r_div      <= DIV_WIDTH'(DEFAULT_DIV);
            r_keep_cs  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_csn      <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            if (w_start) begin
                r_shift  <= writedata[DATA_WIDTH-1:0];
                r_mosi   <= writedata[DATA_WIDTH-1];
                r_bitcnt <= BW'(DATA_WIDTH - 1);
            end
            if (w_enter_hi) begin
                r_sclk  <= 1'b1;
                r_shift <= (r_shift << 1) | DATA_WIDTH'(spi_miso);
            end
            // After the capture shift, the MSB already holds the next bit to send.
            if (w_enter_lo) begin
                r_sclk   <= 1'b0;
                r_mosi   <= r_shift[DATA_WIDTH-1];
                r_bitcnt <= r_bitcnt - 1'b1;
            end
            if (w_enter_hold) begin
                r_sclk <= 1'b0;
            end

            if (w_start) begin
                r_csn <= 1'b0;
            end else if (((r_state == ST_IDLE) || w_done) && !w_keep_nxt) begin
                r_csn <= 1'b1;
            end

            if (w_done) begin
                r_rxdata <= r_shift;
            end
            if (w_done) begin
                r_rx_valid <= 1'b1;
            end else if (w_rd_rx) begin
                r_rx_valid <= 1'b0;
            end

            if (w_wr_tx && w_busy) begin
                r_overrun <= 1'b1;
            end else if (w_wr_stat) begin
                r_overrun <= 1'b0;
            end

            if (w_wr_ctrl) begin
                r_div     <= writedata[DIV_WIDTH-1:0];
                r_keep_cs <= writedata[CTRL_KEEP_CS];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_RXDATA: readdata = 32'(r_rxdata);
            ADDR_STATUS: begin
                readdata[STAT_BUSY]     = w_busy;
                readdata[STAT_RX_VALID] = r_rx_valid;
                readdata[STAT_OVERRUN]  = r_overrun;
            end
            ADDR_CONTROL: begin
                readdata[DIV_WIDTH-1:0] = r_div;
                readdata[CTRL_KEEP_CS]  = r_keep_cs;
            end
            default: readdata = '0;
        endcase
    end

    assign spi_csn  = r_csn;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;

endmodule

// File: doc/mysystem_spi_master_ctrl.md
Name: mysystem_spi_master_ctrl

Overview:
- Avalon-MM slave SPI master (mode 0, MSB first). It sequences chip-select, SCLK and MOSI for one transfer per write, and captures MISO.
- Replaces the software bit-banged CSn/SCLK/MOSI PIOs in mysystem: the CPU writes a byte, polls busy, then reads the received byte.
- Sits on the HPS-to-FPGA lightweight bus next to the other PIO slaves.

Parameters:
- DATA_WIDTH, 8, bits per transfer (1..32).
- DIV_WIDTH, 8, width of the clock-divider field.
- DEFAULT_DIV, 4, reset value of the divider. Half SCLK period = DIV+1 clk cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address.
- spi_csn  out  1  chip select, active low.
- spi_sclk  out  1  serial clock, idle low.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in, treated as synchronous to the generated SCLK.

Behaviour:
- Register map:
  - addr 0 TXDATA (W): write starts a transfer.
  - addr 1 RXDATA (R): last received word, zero-extended. A read with read_n=0 clears rx_valid.
  - addr 2 STATUS (R): bit0 busy, bit1 rx_valid, bit2 overrun. Writing any value to addr 2 clears overrun.
  - addr 3 CONTROL (R/W): bits[DIV_WIDTH-1:0] div, bit16 keep_cs.
  - Unused readdata bits are 0.
- Reset values:
  - spi_csn=1, spi_sclk=0, spi_mosi=0.
  - busy=0, rx_valid=0, overrun=0, RXDATA=0.
  - div=DEFAULT_DIV, keep_cs=0, FSM=IDLE.
- FSM states: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD. One down-counter is loaded with div at each state entry; a state ends when the counter reaches 0, so each state lasts div+1 cycles.
- IDLE:
  - On a TXDATA write (chipselect & ~write_n & addr==0), the next edge loads the shift register, sets spi_csn=0, busy=1, spi_mosi=MSB, bitcnt=DATA_WIDTH-1, and enters SETUP.
  - If keep_cs=0, spi_csn=1 in IDLE.
- SETUP: sclk=0. Then go to SCLK_HI.
- SCLK_HI:
  - On entry, sclk=1 and spi_miso is sampled into the LSB of the shift register (shift left).
  - On exit, if bitcnt==0 go to HOLD; otherwise go to SCLK_LO.
- SCLK_LO:
  - On entry, sclk=0, spi_mosi=next bit, bitcnt decrements.
  - Then go to SCLK_HI.
- HOLD:
  - On entry, sclk=0.
  - On exit: RXDATA is loaded from the shift register, rx_valid=1, busy=0, state goes to IDLE.
  - spi_csn goes to 1 in the same edge unless keep_cs=1.
- Transfer latency, write edge to busy falling: 1 + (2*DATA_WIDTH+1)*(div+1) cycles.
- keep_cs:
  - While keep_cs=1, spi_csn stays 0 between transfers.
  - Clearing keep_cs while IDLE deasserts spi_csn on the next edge.
  - Clearing keep_cs while busy takes effect at the end of HOLD.
- TXDATA write while busy: the data is ignored, overrun=1, and the transfer in progress is unaffected.
- A CONTROL write while busy updates div immediately; the new value applies from the next counter load.
- Simultaneous transfer completion and RXDATA read: set wins, so rx_valid=1.
- Reset mid-transfer forces all reset values immediately (asynchronous): spi_csn=1 and sclk=0 with no glitch to low.
- All SPI outputs are registered.

Decomposition:
- Shared package (mysystem_spi_pkg): register address constants, STATUS bit indices, FSM state encoding.
- One sub-module is natural: mysystem_spi_clkdiv, the down-counter with load/zero flag. Register decode, FSM and shift register stay in the top level.

Test Plan:
- Loopback (miso tied to mosi), div=0, write TXDATA=0xA5 → csn low one cycle after the write; 8 sclk pulses with period 2 clk; busy falls 18 cycles after the write; RXDATA=0xA5; STATUS=0x2.
- miso fixed at 1, div=4, write 0x3C → mosi bit sequence 0,0,1,1,1,1,0,0 with changes only while sclk=0; sclk high/low 5 cycles each; RXDATA=0xFF.
- keep_cs=1, two back-to-back writes 0x01 and 0x02 → csn stays 0 across both transfers; clearing keep_cs → csn=1 on the next edge.
- Write 0x55 then 0x77 while busy → shifted data is 0x55; STATUS bit2=1; a write to addr 2 clears it to 0.
- Assert reset_n=0 at the third sclk high → csn=1, sclk=0, busy=0 asynchronously; div reads back as 4.
- Read RXDATA on the same cycle HOLD completes → rx_valid reads 1 afterwards; a second read clears it.
